// File: rtl/pipe_hazard_buffer_if.sv
// Fetch/execute/writeback hazard-buffer bus: pipeline inputs and buffered stage outputs.
interface pipe_hazard_buffer_if #(
    parameter int unsigned XLEN = 32
);
    logic [XLEN-1:0] inst_f;
    logic [XLEN-1:0] pc_f;
    logic [XLEN-1:0] alu_out_e;
    logic            br_taken;
    logic            dmem_ready;
    logic [XLEN-1:0] irbuffer1_out;
    logic [XLEN-1:0] irbuffer2_out;
    logic [XLEN-1:0] pc_e_out;
    logic [XLEN-1:0] pc_w_out;
    logic [XLEN-1:0] alu_w_out;
    logic            stall_pc;
    logic            flush_f;
    logic            mem_err;

    modport master (
        output inst_f, pc_f, alu_out_e, br_taken, dmem_ready,
        input  irbuffer1_out, irbuffer2_out, pc_e_out, pc_w_out, alu_w_out,
        input  stall_pc, flush_f, mem_err
    );

    modport slave (
        input  inst_f, pc_f, alu_out_e, br_taken, dmem_ready,
        output irbuffer1_out, irbuffer2_out, pc_e_out, pc_w_out, alu_w_out,
        output stall_pc, flush_f, mem_err
    );
endinterface

// File: rtl/pipe_hazard_buffer.sv
// Execute/writeback instruction, PC and ALU buffers for a 3-stage RV32I pipeline,
// with load-use bubbles, branch squash and a memory-wait freeze with timeout.
module pipe_hazard_buffer #(
    parameter int unsigned     XLEN        = 32,
    parameter logic [XLEN-1:0] NOP_INST    = 'h00000013,
    parameter int unsigned     MEM_TIMEOUT = 16
) (
    input logic                clk,
    input logic                rst,
    pipe_hazard_buffer_if.slave bus
);
    localparam int unsigned CW = $clog2(MEM_TIMEOUT + 1);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic {
        RUN,
        MEM_WAIT
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            err_q, err_d;
    logic [XLEN-1:0] ir1_q, ir1_d;
    logic [XLEN-1:0] ir2_q, ir2_d;
    logic [XLEN-1:0] pce_q, pce_d;
    logic [XLEN-1:0] pcw_q, pcw_d;
    logic [XLEN-1:0] aluw_q, aluw_d;
    logic            stall;
    logic            flush;
    logic            advance;

    logic [6:0] op_f, op_e, op_w;
    logic [4:0] rs1_f, rs2_f, rd_e;
    logic       rs1_v_f, rs2_v_f, rd_v_e;
    logic       load_e, mem_w, load_use;

    assign op_f  = bus.inst_f[6:0];
    assign op_e  = ir1_q[6:0];
    assign op_w  = ir2_q[6:0];
    assign rs1_f = bus.inst_f[19:15];
    assign rs2_f = bus.inst_f[24:20];
    assign rd_e  = ir1_q[11:7];

    assign rs1_v_f = (op_f == OP_R) || (op_f == OP_I) || (op_f == OP_LOAD) ||
                     (op_f == OP_STORE) || (op_f == OP_BRANCH) || (op_f == OP_JALR);
    assign rs2_v_f = (op_f == OP_R) || (op_f == OP_STORE) || (op_f == OP_BRANCH);
    assign rd_v_e  = (op_e == OP_R) || (op_e == OP_I) || (op_e == OP_LOAD) || (op_e == OP_LUI) ||
                     (op_e == OP_AUIPC) || (op_e == OP_JAL) || (op_e == OP_JALR);

    assign load_e   = (op_e == OP_LOAD) && rd_v_e && (rd_e != 5'd0);
    assign mem_w    = (op_w == OP_LOAD) || (op_w == OP_STORE);
    assign load_use = load_e && ((rs1_v_f && (rs1_f == rd_e)) || (rs2_v_f && (rs2_f == rd_e)));

    // Next-state: freeze/wait bookkeeping first, then a shared advance path for branch/load-use/normal.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        ir1_d   = ir1_q;
        ir2_d   = ir2_q;
        pce_d   = pce_q;
        pcw_d   = pcw_q;
        aluw_d  = aluw_q;
        stall   = 1'b0;
        flush   = 1'b0;
        advance = 1'b0;

        case (state_q)
            RUN: begin
                if (mem_w && !bus.dmem_ready) begin
                    state_d = MEM_WAIT;
                    cnt_d   = CW'(1);
                    stall   = 1'b1;
                end else begin
                    advance = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (bus.dmem_ready) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    advance = 1'b1;
                end else if (cnt_q == CW'(MEM_TIMEOUT)) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    err_d   = 1'b1;
                    advance = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    stall = 1'b1;
                end
            end
            default: state_d = RUN;
        endcase

        // The release edge out of MEM_WAIT is an ordinary advance, so branch and
        // load-use rules apply to it exactly as in RUN.
        if (advance) begin
            ir2_d  = ir1_q;
            pcw_d  = pce_q;
            aluw_d = bus.alu_out_e;
            if (bus.br_taken) begin
                flush = 1'b1;
                ir1_d = NOP_INST;
                pce_d = '0;
            end else if (load_use) begin
                stall = 1'b1;
                ir1_d = NOP_INST;
                pce_d = '0;
            end else begin
                ir1_d = bus.inst_f;
                pce_d = bus.pc_f;
            end
        end
    end

    // State and buffer registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            ir1_q   <= NOP_INST;
            ir2_q   <= NOP_INST;
            pce_q   <= '0;
            pcw_q   <= '0;
            aluw_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            ir1_q   <= ir1_d;
            ir2_q   <= ir2_d;
            pce_q   <= pce_d;
            pcw_q   <= pcw_d;
            aluw_q  <= aluw_d;
        end
    end

    assign bus.irbuffer1_out = ir1_q;
    assign bus.irbuffer2_out = ir2_q;
    assign bus.pc_e_out      = pce_q;
    assign bus.pc_w_out      = pcw_q;
    assign bus.alu_w_out     = aluw_q;
    assign bus.stall_pc      = stall;
    assign bus.flush_f       = flush;
    assign bus.mem_err       = err_q;
endmodule

// File: tb/tb_pipe_hazard_buffer.sv
// Bench for pipe_hazard_buffer: directed vector table, multi-cycle memory sequences,
// and randomized traffic against a behavioural pipeline model.
module tb_pipe_hazard_buffer;
    localparam logic [31:0] NOP   = 32'h00000013;
    localparam int          TMO   = 4;
    localparam logic [31:0] ADDI1 = 32'h00100093; // addi x1,x0,1
    localparam logic [31:0] ADDI2 = 32'h00200113; // addi x2,x0,2
    localparam logic [31:0] LW5   = 32'h0000A283; // lw x5,0(x1)
    localparam logic [31:0] ADD6  = 32'h00228333; // add x6,x5,x2
    localparam logic [31:0] ADD6B = 32'h00200333; // add x6,x0,x2
    localparam logic [31:0] LW0   = 32'h0000A003; // lw x0,0(x1)
    localparam logic [31:0] ADDX0 = 32'h00000333; // add x6,x0,x0
    localparam logic [31:0] ADDIA = 32'h00A00093; // addi x1,x0,10
    localparam logic [31:0] SW5   = 32'h0050A023; // sw x5,0(x1)
    localparam logic [31:0] LUI7  = 32'h000283B7; // lui x7,0x28 (rs1 field aliases x5)
    localparam logic [31:0] BEQ51 = 32'h00128063; // beq x5,x1,0
    localparam logic [31:0] JAL1  = 32'h000000EF; // jal x1,0
    localparam logic [31:0] LW1   = 32'h0002A083; // lw x1,0(x5)

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    pipe_hazard_buffer_if #(.XLEN(32)) bus ();

    pipe_hazard_buffer #(
        .XLEN(32),
        .NOP_INST(32'h00000013),
        .MEM_TIMEOUT(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_ir1, m_ir2, m_pce, m_pcw, m_aluw;
    logic        m_err;
    int          m_wait;
    logic [31:0] n_ir1, n_ir2, n_pce, n_pcw, n_aluw;
    logic        n_err;
    int          n_wait;

    function automatic bit is_mem(input logic [31:0] i);
        return (i[6:0] == 7'b0000011) || (i[6:0] == 7'b0100011);
    endfunction

    // destination of a load, or 0 when the instruction is not a load
    function automatic logic [4:0] load_dest(input logic [31:0] i);
        return (i[6:0] == 7'b0000011) ? i[11:7] : 5'd0;
    endfunction

    function automatic bit reads(input logic [31:0] i, input logic [4:0] r);
        logic [4:0] a;
        logic [4:0] b;
        a = i[19:15];
        b = i[24:20];
        case (i[6:0])
            7'b0110011, 7'b0100011, 7'b1100011: return (a == r) || (b == r);
            7'b0010011, 7'b0000011, 7'b1100111: return (a == r);
            default:                            return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        m_ir1 = NOP; m_ir2 = NOP; m_pce = '0; m_pcw = '0; m_aluw = '0;
        m_err = 1'b0; m_wait = 0;
    endtask

    task automatic model_eval(input logic [31:0] inst, input logic [31:0] pc, input logic [31:0] alu,
                              input logic br, input logic rdy, output logic e_stall, output logic e_flush);
        bit go;
        n_ir1 = m_ir1; n_ir2 = m_ir2; n_pce = m_pce; n_pcw = m_pcw; n_aluw = m_aluw;
        n_err = m_err; n_wait = m_wait;
        e_stall = 1'b0; e_flush = 1'b0; go = 1'b0;
        if (m_wait == 0) begin
            if (is_mem(m_ir2) && !rdy) begin n_wait = 1; e_stall = 1'b1; end
            else go = 1'b1;
        end else if (rdy) begin
            n_wait = 0; go = 1'b1;
        end else if (m_wait == TMO) begin
            n_wait = 0; n_err = 1'b1; go = 1'b1;
        end else begin
            n_wait = m_wait + 1; e_stall = 1'b1;
        end
        if (go) begin
            n_ir2 = m_ir1; n_pcw = m_pce; n_aluw = alu;
            if (br) begin
                e_flush = 1'b1; n_ir1 = NOP; n_pce = '0;
            end else if (load_dest(m_ir1) != 5'd0 && reads(inst, load_dest(m_ir1))) begin
                e_stall = 1'b1; n_ir1 = NOP; n_pce = '0;
            end else begin
                n_ir1 = inst; n_pce = pc;
            end
        end
    endtask

    task automatic drive(input logic [31:0] inst, input logic [31:0] pc, input logic [31:0] alu,
                         input logic br, input logic rdy);
        bus.inst_f = inst; bus.pc_f = pc; bus.alu_out_e = alu;
        bus.br_taken = br; bus.dmem_ready = rdy;
    endtask

    // one model-checked cycle: combinational outputs before the edge, buffers after
    task automatic cycle(input logic [31:0] inst, input logic [31:0] pc, input logic [31:0] alu,
                         input logic br, input logic rdy);
        logic es, ef;
        drive(inst, pc, alu, br, rdy);
        #2;
        model_eval(inst, pc, alu, br, rdy, es, ef);
        chk("stall_pc", {31'd0, bus.stall_pc}, {31'd0, es});
        chk("flush_f", {31'd0, bus.flush_f}, {31'd0, ef});
        @(posedge clk);
        #1;
        m_ir1 = n_ir1; m_ir2 = n_ir2; m_pce = n_pce; m_pcw = n_pcw; m_aluw = n_aluw;
        m_err = n_err; m_wait = n_wait;
        chk("irbuffer1", bus.irbuffer1_out, m_ir1);
        chk("irbuffer2", bus.irbuffer2_out, m_ir2);
        chk("pc_e", bus.pc_e_out, m_pce);
        chk("pc_w", bus.pc_w_out, m_pcw);
        chk("alu_w", bus.alu_w_out, m_aluw);
        chk("mem_err", {31'd0, bus.mem_err}, {31'd0, m_err});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(NOP, '0, '0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        chk("rst_ir1", bus.irbuffer1_out, NOP);
        chk("rst_ir2", bus.irbuffer2_out, NOP);
        chk("rst_pce", bus.pc_e_out, 32'h0);
        chk("rst_pcw", bus.pc_w_out, 32'h0);
        chk("rst_aluw", bus.alu_w_out, 32'h0);
        chk("rst_err", {31'd0, bus.mem_err}, 32'h0);
        chk("rst_stall", {31'd0, bus.stall_pc}, 32'h0);
        chk("rst_flush", {31'd0, bus.flush_f}, 32'h0);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [31:0] inst, pc, alu;
        logic        br;
        logic        stall, flush;
        logic [31:0] ir1, ir2, pce, pcw, aluw;
    } vec_t;

    vec_t tbl[18];

    function automatic vec_t mk(input logic [31:0] inst, input logic [31:0] pc, input logic [31:0] alu,
                                input logic br, input logic stall, input logic flush,
                                input logic [31:0] ir1, input logic [31:0] ir2, input logic [31:0] pce,
                                input logic [31:0] pcw, input logic [31:0] aluw);
        vec_t v;
        v.inst = inst; v.pc = pc; v.alu = alu; v.br = br; v.stall = stall; v.flush = flush;
        v.ir1 = ir1; v.ir2 = ir2; v.pce = pce; v.pcw = pcw; v.aluw = aluw;
        return v;
    endfunction

    initial begin
        tbl[0]  = mk(ADDI1, 32'h00, 32'hA0, 0, 0, 0, ADDI1, NOP,   32'h00, 32'h00, 32'hA0);
        tbl[1]  = mk(ADDI2, 32'h04, 32'hA1, 0, 0, 0, ADDI2, ADDI1, 32'h04, 32'h00, 32'hA1);
        tbl[2]  = mk(LW5,   32'h08, 32'hA2, 0, 0, 0, LW5,   ADDI2, 32'h08, 32'h04, 32'hA2);
        tbl[3]  = mk(ADD6,  32'h0C, 32'hA3, 0, 1, 0, NOP,   LW5,   32'h00, 32'h08, 32'hA3);
        tbl[4]  = mk(ADD6,  32'h0C, 32'hA4, 0, 0, 0, ADD6,  NOP,   32'h0C, 32'h00, 32'hA4);
        tbl[5]  = mk(LW5,   32'h10, 32'hA5, 0, 0, 0, LW5,   ADD6,  32'h10, 32'h0C, 32'hA5);
        tbl[6]  = mk(ADD6B, 32'h14, 32'hA6, 0, 0, 0, ADD6B, LW5,   32'h14, 32'h10, 32'hA6);
        tbl[7]  = mk(LW0,   32'h18, 32'hA7, 0, 0, 0, LW0,   ADD6B, 32'h18, 32'h14, 32'hA7);
        tbl[8]  = mk(ADDX0, 32'h1C, 32'hA8, 0, 0, 0, ADDX0, LW0,   32'h1C, 32'h18, 32'hA8);
        tbl[9]  = mk(ADDIA, 32'h20, 32'hA9, 1, 0, 1, NOP,   ADDX0, 32'h00, 32'h1C, 32'hA9);
        tbl[10] = mk(LW5,   32'h24, 32'hAA, 0, 0, 0, LW5,   NOP,   32'h24, 32'h00, 32'hAA);
        tbl[11] = mk(ADD6,  32'h28, 32'hAB, 1, 0, 1, NOP,   LW5,   32'h00, 32'h24, 32'hAB);
        tbl[12] = mk(ADDI1, 32'h2C, 32'hAC, 0, 0, 0, ADDI1, NOP,   32'h2C, 32'h00, 32'hAC);
        tbl[13] = mk(LW5,   32'h30, 32'hAD, 0, 0, 0, LW5,   ADDI1, 32'h30, 32'h2C, 32'hAD);
        tbl[14] = mk(SW5,   32'h34, 32'hAE, 0, 1, 0, NOP,   LW5,   32'h00, 32'h30, 32'hAE);
        tbl[15] = mk(SW5,   32'h34, 32'hAF, 0, 0, 0, SW5,   NOP,   32'h34, 32'h00, 32'hAF);
        tbl[16] = mk(LW5,   32'h38, 32'hB0, 0, 0, 0, LW5,   SW5,   32'h38, 32'h34, 32'hB0);
        tbl[17] = mk(LUI7,  32'h3C, 32'hB1, 0, 0, 0, LUI7,  LW5,   32'h3C, 32'h38, 32'hB1);

        do_reset();

        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].inst, tbl[i].pc, tbl[i].alu, tbl[i].br, 1'b1);
            #2;
            chk($sformatf("v%0d_stall", i), {31'd0, bus.stall_pc}, {31'd0, tbl[i].stall});
            chk($sformatf("v%0d_flush", i), {31'd0, bus.flush_f}, {31'd0, tbl[i].flush});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_ir1", i), bus.irbuffer1_out, tbl[i].ir1);
            chk($sformatf("v%0d_ir2", i), bus.irbuffer2_out, tbl[i].ir2);
            chk($sformatf("v%0d_pce", i), bus.pc_e_out, tbl[i].pce);
            chk($sformatf("v%0d_pcw", i), bus.pc_w_out, tbl[i].pcw);
            chk($sformatf("v%0d_aluw", i), bus.alu_w_out, tbl[i].aluw);
            chk($sformatf("v%0d_err", i), {31'd0, bus.mem_err}, 32'h0);
        end

        // load in writeback, memory not ready for three cycles (branch during wait ignored)
        do_reset();
        cycle(LW5,   32'h100, 32'h1, 0, 1);
        cycle(ADDI1, 32'h104, 32'h2, 0, 1);
        cycle(ADDI2, 32'h108, 32'h3, 0, 0);
        cycle(ADDI2, 32'h108, 32'h4, 1, 0);
        cycle(ADDI2, 32'h108, 32'h5, 0, 0);
        cycle(ADDI2, 32'h108, 32'h6, 0, 1);
        cycle(ADD6,  32'h10C, 32'h7, 0, 1);
        chk("wait_no_err", {31'd0, bus.mem_err}, 32'h0);

        // memory never ready: timeout release and sticky error
        cycle(LW5,   32'h200, 32'h10, 0, 1);
        cycle(ADDI1, 32'h204, 32'h11, 0, 1);
        for (int i = 0; i < 6; i++) cycle(ADD6, 32'h208, 32'h20 + i, 0, 0);
        chk("timeout_err", {31'd0, bus.mem_err}, 32'h1);
        for (int i = 0; i < 4; i++) cycle(ADDI2, 32'h300 + 4 * i, 32'h30 + i, 0, 1);
        chk("err_sticky", {31'd0, bus.mem_err}, 32'h1);

        // reset asserted while frozen
        cycle(LW5,   32'h400, 32'h40, 0, 1);
        cycle(ADDI1, 32'h404, 32'h41, 0, 1);
        cycle(ADDI2, 32'h408, 32'h42, 0, 0);
        cycle(ADDI2, 32'h408, 32'h43, 0, 0);
        do_reset();
        cycle(ADDI1, 32'h500, 32'h50, 0, 0);

        // randomized traffic
        do_reset();
        begin
            logic [31:0] pool[12];
            pool[0] = LW5;   pool[1] = LW0;  pool[2] = ADD6;  pool[3] = ADD6B;
            pool[4] = ADDI1; pool[5] = ADDI2; pool[6] = SW5;  pool[7] = LUI7;
            pool[8] = BEQ51; pool[9] = JAL1; pool[10] = LW1;  pool[11] = ADDX0;
            for (int i = 0; i < 400; i++) begin
                cycle(pool[$urandom_range(11)], $urandom, $urandom,
                      ($urandom_range(5) == 0), ($urandom_range(2) != 0));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_buffer.md
Name: pipe_hazard_buffer

Overview:
- Produces the execute-stage and writeback-stage instruction buffers (irbuffer1_out, irbuffer2_out) that the forwarding logic compares, plus the matching PC and ALU-result buffers.
- Sits between fetch, execute and writeback in the 3-stage RV32I pipeline.
- Handles every hazard that forwarding cannot resolve:
  - load-use bubble insertion;
  - squash of the fetched instruction on a taken branch or jump;
  - whole-pipeline freeze while data memory is not ready, with timeout.

Parameters:
- XLEN, 32, datapath and instruction width.
- NOP_INST, 32'h00000013, bubble instruction (addi x0,x0,0).
- MEM_TIMEOUT, 16, maximum consecutive MEM_WAIT cycles before error release.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- inst_f  in  XLEN  instruction from the fetch stage.
- pc_f  in  XLEN  PC of inst_f.
- alu_out_e  in  XLEN  execute-stage ALU result.
- br_taken  in  1  execute instruction is a taken branch, JAL or JALR.
- dmem_ready  in  1  data memory has completed the current load/store.
- irbuffer1_out  out  XLEN  instruction in execute.
- irbuffer2_out  out  XLEN  instruction in writeback.
- pc_e_out  out  XLEN  PC of execute instruction.
- pc_w_out  out  XLEN  PC of writeback instruction.
- alu_w_out  out  XLEN  ALU result buffered for writeback.
- stall_pc  out  1  hold PC and fetch this cycle (combinational).
- flush_f  out  1  fetched instruction is being squashed (combinational).
- mem_err  out  1  sticky, memory timeout occurred.

Behaviour:
- Reset (rst=1 at edge):
  - irbuffer1_out=irbuffer2_out=NOP_INST.
  - pc_e_out=pc_w_out=alu_w_out=0.
  - mem_err=0, timeout counter=0, state=RUN.
  - Reset overrides all events, including mid-MEM_WAIT.
- Decode rules for the hazard checks:
  - rs1 valid for opcodes R, I, load, S, B, JALR.
  - rs2 valid for opcodes R, S, B.
  - rd valid for opcodes R, I, load, LUI, AUIPC, JAL, JALR.
  - x0 never causes a hazard.
- Normal advance (RUN, no event):
  - irbuffer1<=inst_f, pc_e<=pc_f.
  - irbuffer2<=irbuffer1, pc_w<=pc_e, alu_w<=alu_out_e.
- Event priority per cycle: memory freeze > branch flush > load-use > normal.
- Memory freeze:
  - Trigger: state RUN, irbuffer2 opcode is load (0000011) or store (0100011), dmem_ready=0.
  - Action: go to MEM_WAIT; all buffers hold; stall_pc=1; counter<=1.
- MEM_WAIT:
  - All buffers hold; stall_pc=1; br_taken is ignored.
  - dmem_ready=1: perform a normal advance that edge (branch/load-use rules apply), go to RUN, counter<=0.
  - dmem_ready=0 and counter==MEM_TIMEOUT: mem_err<=1, normal advance, go to RUN.
  - Otherwise counter increments.
- Branch flush:
  - Trigger: br_taken=1 (not frozen).
  - flush_f=1; irbuffer1<=NOP_INST, pc_e<=0; irbuffer2/pc_w/alu_w advance normally; stall_pc=0.
- Load-use:
  - Trigger: irbuffer1 is a load with valid rd!=0, and inst_f has a valid rs1 or rs2 equal to that rd.
  - stall_pc=1; irbuffer1<=NOP_INST, pc_e<=0; irbuffer2 side advances (load moves to writeback).
  - Next cycle the held instruction re-presents on inst_f and enters execute after the load writes the register file. This is exactly one bubble.
- Output timing:
  - stall_pc and flush_f are combinational from current state and inputs.
  - All buffer outputs are registered, with one-cycle latency.
- mem_err stays 1 until rst.
- Back-to-back hazards are each handled independently, e.g. load-use immediately after a flush.

Test Plan:
- Reset then stream addi x1,x0,1 / addi x2,x0,2 with dmem_ready=1 -> buffers shift one stage per cycle; stall_pc=0; irbuffer2_out equals the instruction two cycles after it appears on inst_f.
- irbuffer1=lw x5,0(x1), inst_f=add x6,x5,x2 -> stall_pc=1 for one cycle; next irbuffer1=NOP_INST; add enters execute one cycle later. Repeat with add x6,x0,x2 and lw rd=x0 -> no stall.
- br_taken=1 with inst_f=0x00A00093 -> flush_f=1; next irbuffer1=0x00000013, pc_e_out=0; irbuffer2 receives the branch.
- Load in writeback with dmem_ready=0 for 3 cycles -> stall_pc=1 for those cycles; all buffer outputs frozen; advance on the edge when dmem_ready=1; mem_err=0.
- dmem_ready held 0 with MEM_TIMEOUT=4 -> release after 4 wait cycles, mem_err=1 and it stays 1 until rst.
- Assert rst during MEM_WAIT -> next cycle all outputs are at reset values, state RUN, stall_pc=0.
